// File: rtl/tape_level_meter.sv
// Cassette audio level meter: peak-hold magnitude with periodic decay, per-frame latch, and tape position counter.
// tape_data is latched one cycle after frame_start. pos follows the sample stream. There is no backpressure.
module tape_level_meter #(
   parameter int          DECAY_DIV   = 1024,
   parameter int          DECAY_SHIFT = 3,
   parameter int          POS_DIV     = 256,
   parameter logic [24:0] POS_MAX     = 25'h1FFFFFF
) (
   input  logic        i_clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [7:0]  sample,
   input  logic        play,
   input  logic        rewind,
   input  logic        frame_start,
   output logic [7:0]  tape_data,
   output logic        level_valid,
   output logic [24:0] pos
);

   localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam int PW = (POS_DIV > 1) ? $clog2(POS_DIV) : 1;
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);
   localparam logic [PW-1:0] POS_LAST   = PW'(POS_DIV - 1);

   logic [DW-1:0] decay_cnt;
   logic [PW-1:0] sample_cnt;
   logic [7:0]    peak;
   logic [7:0]    peak_nxt;
   logic [6:0]    mag7;
   logic [7:0]    mag;
   logic [7:0]    shr;
   logic [7:0]    dv;
   logic [7:0]    base;
   logic          decay_tick;

   // Offset-binary distance from 0x80; below midpoint this is 0x7F - sample.
   always_comb begin
      mag7 = sample[7] ? sample[6:0] : ~sample[6:0];
      mag  = {mag7, 1'b0};
   end

   // Proportional decay, falling back to unit steps once the shifted term is zero.
   always_comb begin
      shr = peak >> DECAY_SHIFT;
      dv  = 8'd0;
      if (shr != 8'd0) begin
         dv = peak - shr;
      end else if (peak != 8'd0) begin
         dv = peak - 8'd1;
      end
   end

   always_comb begin
      decay_tick = (decay_cnt == DECAY_LAST);
      base       = decay_tick ? dv : peak;
      peak_nxt   = base;
      if (sample_valid && (mag > base)) begin
         peak_nxt = mag;
      end
   end

   always_ff @(posedge i_clk) begin
      if (reset) begin
         decay_cnt <= '0;
         peak      <= 8'd0;
      end else begin
         decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
         peak      <= peak_nxt;
      end
   end

   // The latch takes the registered peak, i.e. the value before this cycle's update.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         tape_data   <= 8'd0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= frame_start;
         if (frame_start) begin
            tape_data <= peak;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (reset) begin
         sample_cnt <= '0;
         pos        <= 25'd0;
      end else if (rewind) begin
         sample_cnt <= '0;
         pos        <= 25'd0;
      end else if (play && sample_valid) begin
         if (sample_cnt == POS_LAST) begin
            sample_cnt <= '0;
            if (pos != POS_MAX) begin
               pos <= pos + 25'd1;
            end
         end else begin
            sample_cnt <= sample_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tape_level_meter.sv
// Directed bench for tape_level_meter: frame latches are scored by a queue-driven monitor, pos is checked inline.
module tb_tape_level_meter;

   localparam int D  = 32;
   localparam int PD = 16;

   logic        i_clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [7:0]  sample;
   logic        play;
   logic        rewind;
   logic        frame_start;
   logic [7:0]  tape_data;
   logic        level_valid;
   logic [24:0] pos;

   int checks   = 0;
   int failures = 0;
   int ph       = 0;
   logic [7:0] sb[$];

   // Expected peak after each successive decay step starting from 0xFE, DECAY_SHIFT = 3.
   logic [7:0] tbl [40] = '{
      8'hFE, 8'hDF, 8'hC4, 8'hAC, 8'h97, 8'h85, 8'h75, 8'h67, 8'h5B, 8'h50,
      8'h46, 8'h3E, 8'h37, 8'h31, 8'h2B, 8'h26, 8'h22, 8'h1E, 8'h1B, 8'h18,
      8'h15, 8'h13, 8'h11, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09,
      8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00};

   tape_level_meter #(
      .DECAY_DIV  (D),
      .DECAY_SHIFT(3),
      .POS_DIV    (PD),
      .POS_MAX    (25'd5)
   ) dut (
      .i_clk       (i_clk),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample      (sample),
      .play        (play),
      .rewind      (rewind),
      .frame_start (frame_start),
      .tape_data   (tape_data),
      .level_valid (level_valid),
      .pos         (pos)
   );

   always #5 i_clk = ~i_clk;

   // Decay-phase reference: cycles since reset, modulo the decay period.
   always @(posedge i_clk) begin
      if (reset) ph <= 0;
      else       ph <= (ph == D - 1) ? 0 : ph + 1;
   end

   always @(negedge i_clk) begin
      if (level_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL level_valid unexpected pulse, tape_data=%02h, none expected", tape_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (tape_data !== e) begin
               failures++;
               $display("FAIL tape_data got=%02h exp=%02h", tape_data, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic align(input int p);
      for (int g = 0; g < 2 * D && ph != p; g++) tick();
      chk("align_phase", ph, p);
   endtask

   task automatic frame(input logic [7:0] exp);
      frame_start = 1'b1;
      sb.push_back(exp);
      tick();
      frame_start = 1'b0;
      tick();
      tick();
   endtask

   task automatic one_sample(input logic [7:0] s);
      sample       = s;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      sample       = 8'h80;
   endtask

   task automatic samples(input int n);
      sample_valid = 1'b1;
      for (int i = 0; i < n; i++) tick();
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample       = 8'h80;
      play         = 1'b0;
      rewind       = 1'b0;
      frame_start  = 1'b0;
      repeat (3) tick();
      chk("reset_tape_data", tape_data, 8'h00);
      chk("reset_level_valid", level_valid, 1'b0);
      chk("reset_pos", pos, 25'd0);
      reset = 1'b0;

      // Silence keeps the meter at zero.
      sample_valid = 1'b1;
      repeat (5) tick();
      frame(8'h00);
      sample_valid = 1'b0;

      // Attack from a single sample at each extreme and just above midpoint.
      do_reset(); align(0); one_sample(8'hFF); tick(); frame(8'hFE);
      do_reset(); align(0); one_sample(8'h00); tick(); frame(8'hFE);
      do_reset(); align(0); one_sample(8'h81); tick(); frame(8'h02);

      // Decay staircase down to zero, one latch per decay step.
      do_reset(); align(0); one_sample(8'hFF);
      align(4); frame(tbl[0]);
      for (int k = 1; k < 40; k++) begin
         align(D - 1);
         tick();
         align(4);
         frame(tbl[k]);
      end

      // Attack coinciding with a decay step: the larger of mag and decayed peak wins.
      do_reset(); align(0); one_sample(8'hC8); frame(8'h90);
      align(D - 1); one_sample(8'hC0); frame(8'h80);
      do_reset(); align(0); one_sample(8'hD0); frame(8'hA0);
      align(D - 1); one_sample(8'hC0); frame(8'h8C);

      // Position counting, hold, rewind and saturation.
      do_reset();
      play = 1'b1;
      samples(3 * PD);
      chk("pos_after_3_blocks", pos, 25'd3);
      play = 1'b0;
      samples(100);
      chk("pos_hold_no_play", pos, 25'd3);
      play = 1'b1;
      samples(8);
      chk("pos_partial_block", pos, 25'd3);
      rewind = 1'b1; sample = 8'hFF; sample_valid = 1'b1;
      tick();
      rewind = 1'b0; sample = 8'h80; sample_valid = 1'b0;
      chk("pos_rewind", pos, 25'd0);
      frame(8'hFE);
      samples(PD - 1);
      chk("pos_subcount_cleared", pos, 25'd0);
      samples(1);
      chk("pos_first_after_rewind", pos, 25'd1);
      samples(10 * PD);
      chk("pos_saturated", pos, 25'd5);

      // Reset beats a simultaneous frame_start and sample.
      reset = 1'b1; frame_start = 1'b1; sample = 8'hFF; sample_valid = 1'b1;
      tick();
      reset = 1'b0; frame_start = 1'b0; sample = 8'h80; sample_valid = 1'b0;
      chk("midreset_tape_data", tape_data, 8'h00);
      chk("midreset_level_valid", level_valid, 1'b0);
      chk("midreset_pos", pos, 25'd0);
      play = 1'b0;
      frame(8'h00);
      tick();
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
